// File: rtl/video_timing_gen_if.sv
// ============================================================================
// Module      : video_timing_gen_if
// Description : Control inputs and raster outputs of the video timing generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface video_timing_gen_if #(
    parameter int X_W = 11,
    parameter int Y_W = 11
) ();
    logic           ce;
    logic           frame_sync;
    logic           hs;
    logic           vs;
    logic           de;
    logic           de_pre;
    logic [X_W-1:0] active_x;
    logic [Y_W-1:0] active_y;
    logic           frame_start;
    logic           line_start;

    modport master (
        input  ce, frame_sync,
        output hs, vs, de, de_pre, active_x, active_y, frame_start, line_start
    );

    modport slave (
        output ce, frame_sync,
        input  hs, vs, de, de_pre, active_x, active_y, frame_start, line_start
    );
endinterface

`default_nettype wire

// File: rtl/video_timing_gen.sv
// ============================================================================
// Module      : video_timing_gen
// Description : Parametrised raster timing generator (sync, DE, early DE,
//               coordinates, frame/line strobes) with clock enable and genlock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_timing_gen #(
    parameter int   H_ACTIVE = 1024,
    parameter int   H_FP     = 24,
    parameter int   H_SYNC   = 136,
    parameter int   H_BP     = 160,
    parameter int   V_ACTIVE = 768,
    parameter int   V_FP     = 3,
    parameter int   V_SYNC   = 6,
    parameter int   V_BP     = 29,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   PREFETCH = 4,
    parameter int   H_W      = 12,
    parameter int   V_W      = 11,
    parameter int   X_W      = 11,
    parameter int   Y_W      = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    video_timing_gen_if.master vid
);

    localparam int c_H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int c_V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int c_HA0     = H_SYNC + H_BP;
    localparam int c_VA0     = V_SYNC + V_BP;

    localparam logic [H_W-1:0] c_H_LAST = H_W'(c_H_TOTAL - 1);
    localparam logic [V_W-1:0] c_V_LAST = V_W'(c_V_TOTAL - 1);

    generate
        if (PREFETCH < 0 || PREFETCH > c_HA0) begin : g_bad_prefetch
            $error("video_timing_gen: PREFETCH must lie in 0..H_SYNC+H_BP");
        end
        if (c_H_TOTAL > (1 << H_W)) begin : g_bad_h_w
            $error("video_timing_gen: H_W too small for H_TOTAL-1");
        end
        if (c_V_TOTAL > (1 << V_W)) begin : g_bad_v_w
            $error("video_timing_gen: V_W too small for V_TOTAL-1");
        end
    endgenerate

    logic [H_W-1:0] h_q, h_d;
    logic [V_W-1:0] v_q, v_d;

    logic           hs_q, hs_d;
    logic           vs_q, vs_d;
    logic           de_q, de_d;
    logic           de_pre_q, de_pre_d;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           frame_start_q, frame_start_d;
    logic           line_start_q, line_start_d;

    int   h_ext, v_ext, hp_ext;
    logic h_act, v_act, hp_act;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (vid.frame_sync) begin
            h_d = '0;
            v_d = '0;
        end else if (h_q == c_H_LAST) begin
            h_d = '0;
            v_d = (v_q == c_V_LAST) ? '0 : v_q + 1'b1;
        end else begin
            h_d = h_q + 1'b1;
        end
    end

    // Outputs decode the next position so they register alongside the counters.
    assign h_ext  = int'(h_d);
    assign v_ext  = int'(v_d);
    assign hp_ext = h_ext + PREFETCH;

    assign h_act  = (h_ext  >= c_HA0) && (h_ext  < c_HA0 + H_ACTIVE);
    assign hp_act = (hp_ext >= c_HA0) && (hp_ext < c_HA0 + H_ACTIVE);
    assign v_act  = (v_ext  >= c_VA0) && (v_ext  < c_VA0 + V_ACTIVE);

    always_comb begin
        hs_d          = (h_ext < H_SYNC) ? HS_POL : ~HS_POL;
        vs_d          = (v_ext < V_SYNC) ? VS_POL : ~VS_POL;
        de_d          = h_act && v_act;
        de_pre_d      = hp_act && v_act;
        x_d           = de_d ? X_W'(h_ext - c_HA0) : '0;
        y_d           = de_d ? Y_W'(v_ext - c_VA0) : '0;
        line_start_d  = (h_d == '0);
        frame_start_d = (h_d == '0) && (v_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q           <= '0;
            v_q           <= '0;
            hs_q          <= HS_POL;
            vs_q          <= VS_POL;
            de_q          <= 1'b0;
            de_pre_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
        end else if (vid.ce) begin
            h_q           <= h_d;
            v_q           <= v_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            de_q          <= de_d;
            de_pre_q      <= de_pre_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_start_q <= frame_start_d;
            line_start_q  <= line_start_d;
        end
    end

    assign vid.hs          = hs_q;
    assign vid.vs          = vs_q;
    assign vid.de          = de_q;
    assign vid.de_pre      = de_pre_q;
    assign vid.active_x    = x_q;
    assign vid.active_y    = y_q;
    assign vid.frame_start = frame_start_q;
    assign vid.line_start  = line_start_q;

endmodule

`default_nettype wire

// File: tb/tb_video_timing_gen.sv
// ============================================================================
// Module      : tb_video_timing_gen
// Description : Scoreboard bench for video_timing_gen in a small raster mode,
//               two instances (active-low sync + prefetch, active-high + none).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_video_timing_gen;

    localparam int HA = 8, HF = 2, HSY = 3, HB = 4;
    localparam int VA = 4, VF = 1, VSY = 2, VB = 1;
    localparam int HT = HA + HF + HSY + HB;
    localparam int VT = VA + VF + VSY + VB;
    localparam int HA0 = HSY + HB;
    localparam int VA0 = VSY + VB;
    localparam int HW = 5, VW = 3, XW = 3, YW = 2;

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          de;
        logic          dp;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          fs;
        logic          ls;
    } obs_t;

    typedef struct {
        obs_t a;
        obs_t b;
    } rec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ce    = 1'b0;
    logic fsync = 1'b0;

    always #5 clk = ~clk;

    video_timing_gen_if #(.X_W(XW), .Y_W(YW)) vif_a ();
    video_timing_gen_if #(.X_W(XW), .Y_W(YW)) vif_b ();

    assign vif_a.ce         = ce;
    assign vif_a.frame_sync = fsync;
    assign vif_b.ce         = ce;
    assign vif_b.frame_sync = fsync;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .PREFETCH(2),
        .H_W(HW), .V_W(VW), .X_W(XW), .Y_W(YW)
    ) u_dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .vid  (vif_a)
    );

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .PREFETCH(0),
        .H_W(HW), .V_W(VW), .X_W(XW), .Y_W(YW)
    ) u_dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .vid  (vif_b)
    );

    // Reference: what the raster must show at position (h,v) by the region rules.
    function automatic obs_t expect_at(int h, int v, bit hp, bit vp, int pf, bit strobes);
        obs_t o;
        bit   vact;
        int   pre;
        vact  = (v >= VA0) && (v < VA0 + VA);
        pre   = h + pf;
        o.hs  = (h < HSY) ? hp : !hp;
        o.vs  = (v < VSY) ? vp : !vp;
        o.de  = vact && (h >= HA0) && (h < HA0 + HA);
        o.dp  = vact && (pre >= HA0) && (pre < HA0 + HA);
        o.x   = o.de ? XW'(h - HA0) : '0;
        o.y   = o.de ? YW'(v - VA0) : '0;
        o.fs  = strobes && (h == 0) && (v == 0);
        o.ls  = strobes && (h == 0);
        return o;
    endfunction

    rec_t exp_q[$];
    int   mh = 0, mv = 0;
    bit   mstrobe = 1'b0;

    initial begin
        rec_t r;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mh = 0; mv = 0; mstrobe = 1'b0;
            end else if (ce) begin
                mstrobe = 1'b1;
                if (fsync) begin
                    mh = 0; mv = 0;
                end else begin
                    mh = mh + 1;
                    if (mh == HT) begin
                        mh = 0;
                        mv = (mv + 1) % VT;
                    end
                end
            end
            r.a = expect_at(mh, mv, 1'b0, 1'b0, 2, mstrobe);
            r.b = expect_at(mh, mv, 1'b1, 1'b1, 0, mstrobe);
            exp_q.push_back(r);
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int per_mode  = 0;
    int per_epoch = 0;
    int timeouts  = 0;

    task automatic chk(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_obs(string t, obs_t a, obs_t e);
        chk({t, ".hs"}, int'(a.hs), int'(e.hs));
        chk({t, ".vs"}, int'(a.vs), int'(e.vs));
        chk({t, ".de"}, int'(a.de), int'(e.de));
        chk({t, ".de_pre"}, int'(a.dp), int'(e.dp));
        chk({t, ".active_x"}, int'(a.x), int'(e.x));
        chk({t, ".active_y"}, int'(a.y), int'(e.y));
        chk({t, ".frame_start"}, int'(a.fs), int'(e.fs));
        chk({t, ".line_start"}, int'(a.ls), int'(e.ls));
    endtask

    // Monitor: compares on the falling edge against the newest expectation.
    initial begin
        rec_t r;
        obs_t oa, ob;
        int   cyc, last_rise, seen_epoch, seen_to;
        bit   have_rise, prev_fs;
        cyc = 0; last_rise = 0; seen_epoch = 0; seen_to = 0;
        have_rise = 1'b0; prev_fs = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (timeouts != seen_to) begin
                seen_to = timeouts;
                n_tests++;
                n_fail++;
                $display("FAIL wait_pos: raster position never reached at %0t", $time);
            end
            if (exp_q.size() > 0) begin
                r = exp_q[$];
                exp_q.delete();
                oa = {vif_a.hs, vif_a.vs, vif_a.de, vif_a.de_pre, vif_a.active_x,
                      vif_a.active_y, vif_a.frame_start, vif_a.line_start};
                ob = {vif_b.hs, vif_b.vs, vif_b.de, vif_b.de_pre, vif_b.active_x,
                      vif_b.active_y, vif_b.frame_start, vif_b.line_start};
                chk_obs("a", oa, r.a);
                chk_obs("b", ob, r.b);
            end
            if (per_epoch != seen_epoch) begin
                seen_epoch = per_epoch;
                have_rise  = 1'b0;
            end
            if (vif_a.frame_start && !prev_fs) begin
                if (have_rise && per_mode != 0)
                    chk("frame_period", cyc - last_rise, per_mode);
                last_rise = cyc;
                have_rise = 1'b1;
            end
            prev_fs = vif_a.frame_start;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_pos(int h, int v);
        for (int i = 0; i < 600; i++) begin
            step();
            if (mh == h && mv == v) return;
        end
        timeouts++;
    endtask

    initial begin
        int fs_hold;
        repeat (3) step();
        rst_n = 1'b1;
        ce    = 1'b1;

        // Free run, three frames, frame period 136 clocks.
        per_mode = HT * VT;
        per_epoch++;
        repeat (3 * HT * VT + 20) step();

        // Alternating clock enable doubles the frame period.
        per_mode = 2 * HT * VT;
        per_epoch++;
        for (int i = 0; i < 3 * 2 * HT * VT + 40; i++) begin
            step();
            ce = ~ce;
        end
        per_mode = 0;
        per_epoch++;
        ce = 1'b1;

        // Genlock restart in the middle of an active line.
        wait_pos(10, 4);
        fsync = 1'b1;
        step();
        fsync = 1'b0;
        repeat (HT * VT) step();

        // Asynchronous reset mid-active.
        wait_pos(9, 5);
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (HT * VT + 10) step();

        // Randomised enable, genlock (including held) and resets.
        fs_hold = 0;
        for (int i = 0; i < 3000; i++) begin
            step();
            ce = ($urandom_range(0, 3) != 0);
            if (fs_hold > 0) begin
                fs_hold--;
                fsync = 1'b1;
            end else begin
                fsync = ($urandom_range(0, 99) == 0);
                if ($urandom_range(0, 299) == 0) fs_hold = $urandom_range(2, 6);
            end
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 799) == 0) rst_n = 1'b0;
        end
        rst_n = 1'b1;
        fsync = 1'b0;
        ce    = 1'b1;
        repeat (3) step();
        #6;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
